// File: rtl/bsg_print_stat_event_fifo.sv
// bsg_print_stat_event_fifo
//
// Timestamping event buffer for print-stat packets seen on the host link.
// Each print-stat pulse is captured together with the global cycle counter
// and queued for a slow consumer. Events that find the queue full are
// dropped and accounted for (sticky overflow flag + saturating drop count).
// Accepted start/end events are balanced in an open counter, with a sticky
// flag for underflow (end with nothing open) or counter overflow.
//
// Ports:
//   clk_i            core clock
//   reset_i          asynchronous, active-high reset
//   print_stat_v_i   one-cycle pulse per print-stat packet
//   print_stat_tag_i tag of that packet; top two bits are the event type
//   global_ctr_i     free-running cycle counter, sampled with the event
//   v_o              head entry valid
//   data_o           head entry {ctr, tag}
//   yumi_i           consumer takes the head this cycle
//   count_o          current occupancy
//   overflow_o       sticky, set on the first dropped event
//   drop_count_o     dropped events, saturating at all-ones
//   open_count_o     accepted starts minus accepted ends, saturating
//   unbalanced_o     sticky, set on end-underflow or open-count overflow
//
// Handshake: the output side is valid/yumi. v_o=1 means data_o holds the
// oldest entry; yumi_i=1 in a cycle with v_o=1 consumes it at the next edge.
// yumi_i with v_o=0 is illegal and ignored. The input side has no
// backpressure: print_stat_v_i is either written or dropped in its cycle.

module bsg_print_stat_event_fifo #(
    parameter int data_width_p     = 32,
    parameter int ctr_width_p      = 64,
    parameter int els_p            = 16,
    parameter int drop_ctr_width_p = 16,
    parameter int open_ctr_width_p = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 print_stat_v_i,
    input  logic [data_width_p-1:0]              print_stat_tag_i,
    input  logic [ctr_width_p-1:0]               global_ctr_i,
    output logic                                 v_o,
    output logic [ctr_width_p+data_width_p-1:0]  data_o,
    input  logic                                 yumi_i,
    output logic [$clog2(els_p+1)-1:0]           count_o,
    output logic                                 overflow_o,
    output logic [drop_ctr_width_p-1:0]          drop_count_o,
    output logic [open_ctr_width_p-1:0]          open_count_o,
    output logic                                 unbalanced_o
);

    localparam int entry_w_lp = ctr_width_p + data_width_p;
    localparam int ptr_w_lp   = $clog2(els_p);
    localparam int cnt_w_lp   = $clog2(els_p + 1);
    localparam logic [cnt_w_lp-1:0] els_lp = cnt_w_lp'(els_p);

    typedef enum logic [1:0] {
        TAG_STAT  = 2'd0,
        TAG_START = 2'd1,
        TAG_END   = 2'd2,
        TAG_RSVD  = 2'd3
    } tag_type_e;

    logic [entry_w_lp-1:0]       mem_q [els_p];

    logic [ptr_w_lp-1:0]         rptr_q, rptr_d;
    logic [ptr_w_lp-1:0]         wptr_q, wptr_d;
    logic [cnt_w_lp-1:0]         count_q, count_d;
    logic                        overflow_q, overflow_d;
    logic [drop_ctr_width_p-1:0] drop_q, drop_d;
    logic [open_ctr_width_p-1:0] open_q, open_d;
    logic                        unbal_q, unbal_d;

    logic      deq, enq, drop, full;
    tag_type_e tag_type;

    always_comb begin
        full     = (count_q == els_lp);
        deq      = yumi_i & (count_q != '0);
        // A full queue still accepts when the head leaves in the same cycle;
        // the freed slot is the one the write pointer already points at.
        enq      = print_stat_v_i & (~full | deq);
        drop     = print_stat_v_i & ~enq;
        tag_type = tag_type_e'(print_stat_tag_i[data_width_p-1 -: 2]);

        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        open_d     = open_q;
        unbal_d    = unbal_q;

        // Pointers are exactly log2(els_p) bits, so the increment wraps.
        if (deq) rptr_d = rptr_q + ptr_w_lp'(1);
        if (enq) wptr_d = wptr_q + ptr_w_lp'(1);

        case ({enq, deq})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + drop_ctr_width_p'(1);
        end

        // Only accepted events take part in start/end balancing.
        if (enq) begin
            case (tag_type)
                TAG_START: begin
                    if (open_q == '1) unbal_d = 1'b1;
                    else              open_d  = open_q + open_ctr_width_p'(1);
                end
                TAG_END: begin
                    if (open_q == '0) unbal_d = 1'b1;
                    else              open_d  = open_q - open_ctr_width_p'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            open_q     <= '0;
            unbal_q    <= 1'b0;
        end else begin
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            open_q     <= open_d;
            unbal_q    <= unbal_d;
        end
    end

    // Storage contents are don't-care after reset, so the array has no reset.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q] <= {global_ctr_i, print_stat_tag_i};
    end

    assign v_o          = (count_q != '0);
    assign data_o       = mem_q[rptr_q];
    assign count_o      = count_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_q;
    assign open_count_o = open_q;
    assign unbalanced_o = unbal_q;

endmodule

// File: tb/tb_bsg_print_stat_event_fifo.sv
// Directed testbench for bsg_print_stat_event_fifo with the default
// parameters (32-bit tags, 64-bit counter, 16 entries, 16-bit drop counter,
// 8-bit open counter). Inputs are driven 1 time unit after the rising edge
// and outputs are sampled at the same point, after the edge has settled.

module tb_bsg_print_stat_event_fifo;

    logic        clk_i;
    logic        reset_i;
    logic        print_stat_v_i;
    logic [31:0] print_stat_tag_i;
    logic [63:0] global_ctr_i;
    logic        v_o;
    logic [95:0] data_o;
    logic        yumi_i;
    logic [4:0]  count_o;
    logic        overflow_o;
    logic [15:0] drop_count_o;
    logic [7:0]  open_count_o;
    logic        unbalanced_o;

    int total;
    int passed;

    bsg_print_stat_event_fifo #(
        .data_width_p    (32),
        .ctr_width_p     (64),
        .els_p           (16),
        .drop_ctr_width_p(16),
        .open_ctr_width_p(8)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .print_stat_v_i  (print_stat_v_i),
        .print_stat_tag_i(print_stat_tag_i),
        .global_ctr_i    (global_ctr_i),
        .v_o             (v_o),
        .data_o          (data_o),
        .yumi_i          (yumi_i),
        .count_o         (count_o),
        .overflow_o      (overflow_o),
        .drop_count_o    (drop_count_o),
        .open_count_o    (open_count_o),
        .unbalanced_o    (unbalanced_o)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // yumi_i without a valid head is a consumer protocol error.
    always @(posedge clk_i) begin
        if (!reset_i && yumi_i) begin
            total++;
            assert (v_o === 1'b1) begin
                passed++;
            end else begin
                $error("FAIL protocol: yumi_i with v_o=%0b required 1", v_o);
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ent(input logic [63:0] c, input logic [31:0] t);
        return {32'b0, c, t};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] tag, input logic [63:0] ctr,
                         input logic y);
        print_stat_v_i   = v;
        print_stat_tag_i = tag;
        global_ctr_i     = ctr;
        yumi_i           = y;
    endtask

    initial begin
        total = 0;
        passed = 0;
        reset_i = 1'b1;
        drive(1'b0, 32'h0, 64'h0, 1'b0);

        // reset state
        tick();
        tick();
        reset_i = 1'b0;
        chk("rst_v", 128'(v_o), 128'(0));
        chk("rst_count", 128'(count_o), 128'(0));
        chk("rst_overflow", 128'(overflow_o), 128'(0));
        chk("rst_drop", 128'(drop_count_o), 128'(0));
        chk("rst_open", 128'(open_count_o), 128'(0));
        chk("rst_unbal", 128'(unbalanced_o), 128'(0));

        // three events: stat, start, end
        drive(1'b1, 32'h0000_0005, 64'd100, 1'b0);
        tick();
        chk("t1_v_after_1", 128'(v_o), 128'(1));
        chk("t1_data_after_1", 128'(data_o), ent(64'd100, 32'h5));
        chk("t1_count_after_1", 128'(count_o), 128'(1));
        drive(1'b1, 32'h4000_0001, 64'd101, 1'b0);
        tick();
        chk("t1_open_after_start", 128'(open_count_o), 128'(1));
        drive(1'b1, 32'h8000_0001, 64'd102, 1'b0);
        tick();
        drive(1'b0, 32'h0, 64'd0, 1'b0);
        chk("t1_count", 128'(count_o), 128'(3));
        chk("t1_open", 128'(open_count_o), 128'(0));
        chk("t1_unbal", 128'(unbalanced_o), 128'(0));
        chk("t1_head", 128'(data_o), ent(64'd100, 32'h5));
        tick();
        chk("t1_head_stable", 128'(data_o), ent(64'd100, 32'h5));
        chk("t1_drain0", 128'(data_o), ent(64'd100, 32'h0000_0005));
        yumi_i = 1'b1; tick(); yumi_i = 1'b0;
        chk("t1_drain1", 128'(data_o), ent(64'd101, 32'h4000_0001));
        yumi_i = 1'b1; tick(); yumi_i = 1'b0;
        chk("t1_drain2", 128'(data_o), ent(64'd102, 32'h8000_0001));
        yumi_i = 1'b1; tick(); yumi_i = 1'b0;
        chk("t1_empty_v", 128'(v_o), 128'(0));
        chk("t1_empty_count", 128'(count_o), 128'(0));

        // fill 16, then 4 dropped
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(i), 64'(1000 + i), 1'b0);
            tick();
        end
        chk("t2_full_count", 128'(count_o), 128'(16));
        chk("t2_no_drop_yet", 128'(overflow_o), 128'(0));
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(100 + i), 64'(2000 + i), 1'b0);
            tick();
            if (i == 0) chk("t2_overflow_first", 128'(overflow_o), 128'(1));
        end
        drive(1'b0, 32'h0, 64'd0, 1'b0);
        chk("t2_count", 128'(count_o), 128'(16));
        chk("t2_drop", 128'(drop_count_o), 128'(4));
        chk("t2_overflow", 128'(overflow_o), 128'(1));
        chk("t2_head", 128'(data_o), ent(64'd1000, 32'd0));

        // full + simultaneous enqueue/dequeue
        drive(1'b1, 32'h0000_00AA, 64'd3000, 1'b1);
        tick();
        drive(1'b0, 32'h0, 64'd0, 1'b0);
        chk("t3_count", 128'(count_o), 128'(16));
        chk("t3_drop", 128'(drop_count_o), 128'(4));
        for (int i = 1; i < 16; i++) begin
            chk("t2_drain", 128'(data_o), ent(64'(1000 + i), 32'(i)));
            yumi_i = 1'b1; tick(); yumi_i = 1'b0;
        end
        chk("t3_last", 128'(data_o), ent(64'd3000, 32'h0000_00AA));
        yumi_i = 1'b1; tick(); yumi_i = 1'b0;
        chk("t3_empty", 128'(count_o), 128'(0));

        // 40 pairs at occupancy 1
        drive(1'b1, 32'h0000_0100, 64'd5000, 1'b0);
        tick();
        for (int i = 1; i <= 40; i++) begin
            chk("t4_data", 128'(data_o), ent(64'(5000 + i - 1), 32'(32'h100 + i - 1)));
            drive(1'b1, 32'(32'h100 + i), 64'(5000 + i), 1'b1);
            tick();
            chk("t4_count", 128'(count_o), 128'(1));
        end
        drive(1'b0, 32'h0, 64'd0, 1'b0);
        chk("t4_final", 128'(data_o), ent(64'd5040, 32'h0000_0128));
        yumi_i = 1'b1; tick(); yumi_i = 1'b0;
        chk("t4_empty", 128'(v_o), 128'(0));

        // end with nothing open
        drive(1'b1, 32'h8000_0000, 64'd6000, 1'b0);
        tick();
        drive(1'b0, 32'h0, 64'd0, 1'b0);
        chk("t5_unbal", 128'(unbalanced_o), 128'(1));
        chk("t5_open", 128'(open_count_o), 128'(0));

        // burst interrupted by asynchronous reset between edges
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h4000_0000, 64'(6100 + i), 1'b0);
            tick();
        end
        chk("t6_pre_count", 128'(count_o), 128'(6));
        #3;
        reset_i = 1'b1;
        #1;
        chk("t6_rst_v", 128'(v_o), 128'(0));
        chk("t6_rst_count", 128'(count_o), 128'(0));
        chk("t6_rst_overflow", 128'(overflow_o), 128'(0));
        chk("t6_rst_drop", 128'(drop_count_o), 128'(0));
        chk("t6_rst_open", 128'(open_count_o), 128'(0));
        chk("t6_rst_unbal", 128'(unbalanced_o), 128'(0));
        drive(1'b0, 32'h0, 64'd0, 1'b0);
        tick();
        reset_i = 1'b0;
        drive(1'b1, 32'h0000_0077, 64'd7000, 1'b0);
        chk("t6_pre_v", 128'(v_o), 128'(0));
        tick();
        drive(1'b0, 32'h0, 64'd0, 1'b0);
        chk("t6_post_v", 128'(v_o), 128'(1));
        chk("t6_post_data", 128'(data_o), ent(64'd7000, 32'h0000_0077));
        chk("t6_post_count", 128'(count_o), 128'(1));
        yumi_i = 1'b1; tick(); yumi_i = 1'b0;

        // 300 starts, consumer keeps up so nothing is dropped
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 32'h4000_0000, 64'(8000 + i), v_o);
            tick();
            if (i == 254) begin
                chk("t7_open_255", 128'(open_count_o), 128'(255));
                chk("t7_unbal_before", 128'(unbalanced_o), 128'(0));
            end
            if (i == 255) chk("t7_unbal_sat", 128'(unbalanced_o), 128'(1));
        end
        drive(1'b0, 32'h0, 64'd0, 1'b0);
        chk("t7_open", 128'(open_count_o), 128'(255));
        chk("t7_drop", 128'(drop_count_o), 128'(0));
        chk("t7_overflow", 128'(overflow_o), 128'(0));
        chk("t7_count", 128'(count_o), 128'(1));
        chk("t7_last", 128'(data_o), ent(64'd8299, 32'h4000_0000));
        yumi_i = 1'b1; tick(); yumi_i = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
